// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 16:1 bit mux: walks the enabled channels in ascending
// order, waits SETTLE cycles on each, samples mux_out, and publishes one snapshot.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mask,
  input  logic        mux_out,
  output logic [3:0]  mux_sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] snapshot,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  // With no settle time a channel is sampled on the edge right after selection.
  localparam state_t CH_STATE = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  // Handshake: start is a level sampled each rising edge; it is accepted only
  // in IDLE (busy=0). done is a single-cycle pulse marking a new snapshot.

  state_t      state_q, state_d;
  logic [3:0]  mux_sel_q, mux_sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] scratch_q, scratch_d;
  logic [15:0] snapshot_q, snapshot_d;
  logic        done_q, done_d;

  logic [3:0]  first_ch;
  logic [3:0]  next_ch;
  logic        next_found;

  // Descending loops so the lowest qualifying index is the last one written.
  always_comb begin
    first_ch = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) first_ch = 4'(i);
    end
  end

  always_comb begin
    next_ch    = 4'd0;
    next_found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(mux_sel_q))) begin
        next_ch    = 4'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mux_sel_d  = mux_sel_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    scratch_d  = scratch_q;
    snapshot_d = snapshot_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mask != 16'h0000) begin
            mask_d    = mask;
            scratch_d = 16'h0000;
            mux_sel_d = first_ch;
            cnt_d     = SETTLE_CNT;
            state_d   = CH_STATE;
          end else begin
            snapshot_d = 16'h0000;
            done_d     = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        scratch_d[mux_sel_q] = mux_out;
        if (next_found) begin
          mux_sel_d = next_ch;
          cnt_d     = SETTLE_CNT;
          state_d   = CH_STATE;
        end else begin
          snapshot_d = scratch_d;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mux_sel_q  <= 4'd0;
      cnt_q      <= 4'd0;
      mask_q     <= 16'h0000;
      scratch_q  <= 16'h0000;
      snapshot_q <= 16'h0000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mux_sel_q  <= mux_sel_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      scratch_q  <= scratch_d;
      snapshot_q <= snapshot_d;
      done_q     <= done_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign snapshot  = snapshot_q;
  assign dbg_state = state_q;

endmodule
